// File: rtl/decimal_key_pkg.sv
// Shared types and helpers for the decimal key arbiter: key vectors, BCD codes,
// output FSM states and the index-to-BCD encoder.
package decimal_key_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [BCD_W-1:0]    bcd_t;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  // Indices above 9 cannot be granted; they fall back to 0000.
  function automatic bcd_t idx_to_bcd(input logic [3:0] idx);
    bcd_t code;
    code = '0;
    if (idx <= 4'd9) code = idx;
    return code;
  endfunction

endpackage

// File: rtl/decimal_key_arbiter_rr_pick10.sv
// Combinational round-robin picker over 10 request lines, searching upward from
// the slot after the last grant and wrapping 9 -> 0.
module rr_pick10
  import decimal_key_pkg::*;
(
  input  logic [NUM_KEYS-1:0] pending,
  input  logic [3:0]          ptr,
  output logic [NUM_KEYS-1:0] grant_onehot,
  output logic [3:0]          grant_idx,
  output logic                any
);

  // Modulo-10 add that stays correct even for an out-of-range base.
  function automatic logic [3:0] wrap_add(input logic [3:0] base, input logic [3:0] step);
    logic [4:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 5'd10) sum = sum - 5'd10;
    if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

  always_comb begin
    logic [3:0] cand;
    cand         = '0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      cand = wrap_add(ptr, 4'(k));
      if (!any && pending[cand]) begin
        any               = 1'b1;
        grant_idx         = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decimal_key_arbiter.sv
// Synchronises 10 decimal key lines, latches each press as pending and serialises
// them round-robin through one BCD encoder onto a valid/ready output.
module decimal_key_arbiter
  import decimal_key_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [BCD_W-1:0]    bcd_out,
  output logic                bcd_valid,
  input  logic                bcd_ready,
  output logic [NUM_KEYS-1:0] pending,
  output logic                drop_err,
  output logic                busy
);

  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_chain;
  key_vec_t   sync_d;
  key_vec_t   rise;
  key_vec_t   pick_onehot;
  key_vec_t   grant_vec;
  logic [3:0] pick_idx;
  logic [3:0] ptr;
  logic       pick_any;
  logic       grant_en;
  state_t     state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
      sync_d     <= '0;
    end else begin
      sync_chain[0] <= key_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
      sync_d <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign rise = sync_chain[SYNC_STAGES-1] & ~sync_d;

  rr_pick10 u_pick (
    .pending      (pending),
    .ptr          (ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  // A grant happens whenever the output slot is free or is being emptied this edge.
  assign grant_en  = pick_any & ((state == ST_IDLE) | bcd_ready);
  assign grant_vec = grant_en ? pick_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      ptr       <= 4'd9;
      pending   <= '0;
      drop_err  <= 1'b0;
    end else begin
      pending  <= rise | (pending & ~grant_vec);
      drop_err <= |(rise & pending & ~grant_vec);
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            state     <= ST_HOLD;
            bcd_valid <= 1'b1;
            bcd_out   <= idx_to_bcd(pick_idx);
            ptr       <= pick_idx;
          end
        end
        ST_HOLD: begin
          if (grant_en) begin
            bcd_out <= idx_to_bcd(pick_idx);
            ptr     <= pick_idx;
          end else if (bcd_ready) begin
            state     <= ST_IDLE;
            bcd_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bcd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = bcd_valid | (|pending);

endmodule

// File: tb/tb_decimal_key_arbiter.sv
// Self-checking bench for decimal_key_arbiter: directed scenarios with fixed
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_decimal_key_arbiter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_in;
  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [9:0] pending;
  logic       drop_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decimal_key_arbiter #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .pending   (pending),
    .drop_err  (drop_err),
    .busy      (busy)
  );

  // Reference model: a press is a 0->1 change between key samples S and S+1 edges
  // old; pending presses are served round-robin from the slot after the last grant.
  logic [9:0] hist [0:S+1];
  logic [9:0] m_pend;
  logic       m_valid;
  logic [3:0] m_out;
  logic       m_drop;
  int         m_ptr;

  always @(posedge clk or posedge rst) begin
    logic [9:0] r;
    logic [9:0] g;
    int         gi;
    bit         fire;
    if (rst) begin
      for (int j = 0; j <= S + 1; j++) hist[j] = '0;
      m_pend = '0; m_valid = 1'b0; m_out = '0; m_drop = 1'b0; m_ptr = 9;
    end else begin
      for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key_in;
      r = hist[S] & ~hist[S+1];
      g = '0;
      gi = 0;
      fire = m_valid && bcd_ready;
      if (!m_valid || bcd_ready) begin
        for (int k = 1; k <= 10; k++) begin
          if (g == '0 && m_pend[(m_ptr + k) % 10]) begin
            gi = (m_ptr + k) % 10;
            g[gi] = 1'b1;
          end
        end
      end
      m_drop = |(r & m_pend & ~g);
      m_pend = (m_pend & ~g) | r;
      if (g != '0) begin
        m_valid = 1'b1; m_out = 4'(gi); m_ptr = gi;
      end else if (fire) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = '0; bcd_ready = 1'b1;
    #3;
    apply_reset();
    checks++;
    if (bcd_valid !== 1'b0 || pending !== 10'h000 || bcd_out !== 4'h0 || drop_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b pending=%h out=%h drop=%b busy=%b, want all zero",
               bcd_valid, pending, bcd_out, drop_err, busy);
    end
  endtask

  task automatic test_single_press();
    int valid_cnt = 0;
    int drop_cnt = 0;
    bcd_ready = 1'b1;
    key_in = 10'h010;
    tick();
    tick();
    checks++;
    if (pending !== 10'h000 || bcd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_early: pending=%h valid=%b, want 000/0", pending, bcd_valid);
    end
    tick();
    checks++;
    if (pending !== 10'h010 || bcd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pending: pending=%h valid=%b, want 010/0", pending, bcd_valid);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h4 || pending !== 10'h000) begin
      errors++; $display("[TB] FAIL single_out: valid=%b out=%h pending=%h, want 1/4/000", bcd_valid, bcd_out, pending);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bcd_valid) valid_cnt++;
      if (drop_err) drop_cnt++;
    end
    checks++;
    if (valid_cnt != 0 || drop_cnt != 0) begin
      errors++; $display("[TB] FAIL single_held: extra valid cycles=%0d drops=%0d, want 0/0", valid_cnt, drop_cnt);
    end
    key_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_out [3] = '{4'h2, 4'h5, 4'h9};
    logic [9:0] exp_pnd [3] = '{10'h220, 10'h200, 10'h000};
    apply_reset();
    bcd_ready = 1'b1;
    key_in = 10'h224;
    repeat (3) tick();
    checks++;
    if (pending !== 10'h224 || bcd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rr_pending: pending=%h valid=%b, want 224/0", pending, bcd_valid);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (bcd_valid !== 1'b1 || bcd_out !== exp_out[n] || pending !== exp_pnd[n]) begin
        errors++; $display("[TB] FAIL rr_step%0d: valid=%b out=%h pending=%h, want 1/%h/%h",
                           n, bcd_valid, bcd_out, pending, exp_out[n], exp_pnd[n]);
      end
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rr_idle: valid=%b busy=%b, want 0/0", bcd_valid, busy);
    end
    key_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    bcd_ready = 1'b1;
    key_in = 10'h080;
    repeat (6) tick();
    key_in = '0;
    repeat (4) tick();
    key_in = 10'h102;
    repeat (3) tick();
    checks++;
    if (pending !== 10'h102) begin
      errors++; $display("[TB] FAIL wrap_pending: pending=%h, want 102", pending);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h8) begin
      errors++; $display("[TB] FAIL wrap_first: valid=%b out=%h, want 1/8", bcd_valid, bcd_out);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h1 || pending !== 10'h000) begin
      errors++; $display("[TB] FAIL wrap_second: valid=%b out=%h pending=%h, want 1/1/000", bcd_valid, bcd_out, pending);
    end
    key_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bcd_ready = 1'b0;
    key_in = 10'h008;
    repeat (4) tick();
    key_in = 10'h048;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bcd_valid !== 1'b1 || bcd_out !== 4'h3) begin
        errors++; $display("[TB] FAIL bp_hold%0d: valid=%b out=%h, want 1/3", c, bcd_valid, bcd_out);
      end
    end
    checks++;
    if (pending !== 10'h040) begin
      errors++; $display("[TB] FAIL bp_pending: pending=%h, want 040", pending);
    end
    bcd_ready = 1'b1;
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h6 || pending !== 10'h000) begin
      errors++; $display("[TB] FAIL bp_release: valid=%b out=%h pending=%h, want 1/6/000", bcd_valid, bcd_out, pending);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_idle: valid=%b, want 0", bcd_valid);
    end
    key_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_drop();
    int drop_cnt = 0;
    apply_reset();
    bcd_ready = 1'b0;
    key_in = 10'h020;
    repeat (4) tick();
    key_in = 10'h030;
    repeat (4) tick();
    key_in = 10'h020;
    repeat (3) tick();
    key_in = 10'h030;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (drop_err) drop_cnt++;
    end
    checks++;
    if (drop_cnt != 1 || pending !== 10'h010 || bcd_out !== 4'h5) begin
      errors++; $display("[TB] FAIL drop_pulse: pulses=%0d pending=%h out=%h, want 1/010/5", drop_cnt, pending, bcd_out);
    end
    key_in = 10'h020;
    repeat (3) tick();
    key_in = 10'h030;
    tick();
    tick();
    bcd_ready = 1'b1;
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h4 || pending !== 10'h010 || drop_err !== 1'b0) begin
      errors++; $display("[TB] FAIL set_wins: valid=%b out=%h pending=%h drop=%b, want 1/4/010/0",
                         bcd_valid, bcd_out, pending, drop_err);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h4 || pending !== 10'h000 || drop_err !== 1'b0) begin
      errors++; $display("[TB] FAIL set_wins_regrant: valid=%b out=%h pending=%h drop=%b, want 1/4/000/0",
                         bcd_valid, bcd_out, pending, drop_err);
    end
    key_in = '0;
    repeat (5) tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bcd_ready = 1'b0;
    key_in = 10'h080;
    repeat (4) tick();
    key_in = 10'h08E;
    repeat (4) tick();
    checks++;
    if (bcd_valid !== 1'b1 || pending !== 10'h00E) begin
      errors++; $display("[TB] FAIL ar_setup: valid=%b pending=%h, want 1/00E", bcd_valid, pending);
    end
    #3;
    rst = 1'b1;
    key_in = '0;
    #1;
    checks++;
    if (bcd_valid !== 1'b0 || pending !== 10'h000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ar_immediate: valid=%b pending=%h busy=%b, want 0/000/0", bcd_valid, pending, busy);
    end
    tick();
    rst = 1'b0;
    bcd_ready = 1'b1;
    key_in = 10'h101;
    repeat (4) tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h0) begin
      errors++; $display("[TB] FAIL ar_first_key0: valid=%b out=%h, want 1/0", bcd_valid, bcd_out);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== 4'h8) begin
      errors++; $display("[TB] FAIL ar_then_key8: valid=%b out=%h, want 1/8", bcd_valid, bcd_out);
    end
    key_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic [9:0] flip;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      flip = 10'($urandom & $urandom & $urandom);
      key_in = key_in ^ flip;
      bcd_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (bcd_valid !== m_valid || pending !== m_pend || drop_err !== m_drop ||
          busy !== (m_valid | (|m_pend)) || (m_valid && bcd_out !== m_out)) begin
        errors++;
        $display("[TB] FAIL rand_cycle%0d: valid=%b out=%h pending=%h drop=%b busy=%b, want %b/%h/%h/%b/%b",
                 c, bcd_valid, bcd_out, pending, drop_err, busy,
                 m_valid, m_out, m_pend, m_drop, m_valid | (|m_pend));
      end
    end
    key_in = '0;
    bcd_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rand_drain: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_press();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_drop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decimal_key_arbiter.md
Name: decimal_key_arbiter

Overview:
- Shares a single one-hot-to-BCD encode path between 10 decimal key lines (key 0..9).
- Each key press is synchronised, rising-edge detected and latched as pending.
- A round-robin scheduler grants one pending key at a time, encodes its index to BCD and presents it on a valid/ready output, so no press is lost while the consumer stalls.
- Sits between the raw keypad/switch inputs and the digit-entry or display logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the per-key input synchroniser (legal range 2..4).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  10  raw key levels; bit i = decimal digit i; asynchronous to clk.
- bcd_out  output  4  BCD code of granted key (0000..1001).
- bcd_valid  output  1  bcd_out holds an undelivered digit.
- bcd_ready  input  1  consumer accepts; transfer ("fire") = bcd_valid & bcd_ready at a rising edge.
- pending  output  10  latched, not-yet-granted presses.
- drop_err  output  1  one-cycle pulse: a press was lost because that key was already pending.
- busy  output  1  bcd_valid | (|pending).

Behaviour:
- Reset (async, immediate): sync chain = 0, edge-detect history = 0, pending = 0, bcd_out = 0000, bcd_valid = 0, drop_err = 0, rr pointer = 9 (key 0 has first priority). A reset mid-transfer drops bcd_valid at once and discards all pending presses.
- Synchroniser: SYNC_STAGES flops per bit; sync_d is one more flop; rise[i] = sync[i] & ~sync_d[i].
- Pending update per bit, evaluated each edge:
  - set if rise[i];
  - else clear if key i is granted this cycle;
  - else hold.
  - Set wins over clear, so a new press on the key being granted stays pending.
- drop_err: registered pulse = |(rise & pending & ~grant_onehot). Multiple drops in one cycle give one pulse.
- Output FSM has 2 states:
  - IDLE (bcd_valid = 0): if |pending, grant a key, load bcd_out and go to HOLD; else stay.
  - HOLD (bcd_valid = 1): if !bcd_ready, hold bcd_out and bcd_valid stable (no grant). If fire and |pending, grant and reload in the same edge, staying in HOLD (back-to-back, 1 digit/cycle). If fire and no pending, go to IDLE.
- Round robin:
  - Search starts at index ptr+1 mod 10 and wraps 9 -> 0.
  - The first pending bit found is granted; ptr <- granted index.
  - Pending bits are those registered before the grant edge; rises in the same cycle are not eligible.
  - ptr changes only on a grant.
- Encoding: granted index i -> bcd_out = i[3:0]. Indices 10..15 are unreachable; the encoder default is 0000.
- Latency: key_in first sampled high at edge k -> pending[i] set at edge k+SYNC_STAGES -> bcd_valid at edge k+SYNC_STAGES+1 (IDLE, bcd_ready don't-care).
- Holding a key high yields exactly one digit. A release followed by a re-press yields another.

Decomposition:
- Package decimal_key_pkg holds: NUM_KEYS = 10, BCD_W = 4, typedef key_vec_t (logic [9:0]), typedef bcd_t (logic [3:0]), the state enum {ST_IDLE, ST_HOLD}, and the function idx_to_bcd.
- One sub-module is natural: rr_pick10. It is purely combinational: (pending, ptr) -> grant_onehot, grant_idx, any.
- Synchroniser, edge detect, pending register and FSM stay in the top module.

Test Plan:
- Reset/single press: rst pulse, then key_in = 10'b00_0001_0000 held 20 cycles, bcd_ready = 1. Expect one transfer bcd_out = 0100, bcd_valid rising exactly SYNC_STAGES+1 edges after first sample, then IDLE, drop_err = 0.
- Round-robin fairness: keys 2, 5, 9 rise in the same cycle, ptr = 9, bcd_ready = 1. Expect back-to-back outputs 0010, 0101, 1001 on consecutive cycles, pending going 0x224 -> 0x220 -> 0x200 -> 0.
- Wrap-around: after a grant of key 7, keys 1 and 8 pending. Expect 1000 before 0001.
- Backpressure: key 3 pressed, bcd_ready = 0 for 10 cycles while key 6 is pressed. Expect bcd_out = 0011 stable with bcd_valid = 1 throughout, pending[6] = 1. Then bcd_ready = 1 gives 0011 then 0110.
- Drop/set-wins:
  - key 4 pending, bcd_ready = 0, then a release and re-press of key 4 -> single drop_err pulse, pending[4] stays 1.
  - Separately, a re-press rising in the same cycle key 4 is granted -> no drop_err, pending[4] = 1 after the grant.
- Async reset mid-operation: bcd_valid = 1 with 3 keys pending, assert rst between clock edges. Expect bcd_valid, pending, busy = 0 immediately. After release, the first press of key 0 yields 0000 (ptr restored to 9).
